afifo_wr_ctrl: RTL and testbench

//   Write-domain pointer controller for the async FIFO. It accepts writes over a valid/ready handshake
//   and drives the RAM write enable and address. It publishes a Gray-coded write pointer to the

---
 rtl/afifo_pkg.sv | 15 +
 rtl/afifo_wr_ctrl.sv | 79 +++++++
 tb/tb_afifo_wr_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// afifo_pkg: shared state type and Gray/binary conversions for the async FIFO pointer controllers.
package afifo_pkg;
  localparam int GW = 32;
  typedef enum logic {INIT, RUN} wr_state_e;
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Callers zero-extend narrower pointers, so the unused top bits decode to zero.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b = '0;
    for (int i = 0; i < GW; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl: write-domain pointer controller; drives RAM writes and derives full/almost_full/level from the synced read pointer.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  ptr_err
);
  localparam int P  = ADDR_WIDTH + 1;
  localparam int CW = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [P-1:0] DEPTH = P'(1 << ADDR_WIDTH);
  localparam logic [P-1:0] AF    = P'(AF_LEVEL);
  wr_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [P-1:0]  r_wbin, r_wgray, r_level;
  logic [P-1:0]  w_wbin_nxt, w_wgray_nxt, w_rbin, w_level_nxt;
  logic          r_full, r_af, r_err;
  logic          w_done, w_acc, w_full_nxt;
  // INIT waits for the synchronizer to flush its reset value before trusting rptr.
  always_comb begin
    w_done      = r_cnt == CW'(SYNC_STAGES);
    w_state_nxt = (r_state == INIT && w_done) ? RUN : r_state;
    w_cnt_nxt   = (r_state == INIT && !w_done) ? r_cnt + 1'b1 : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  assign wr_ready    = (r_state == RUN) & ~r_full;
  assign w_acc       = wr_valid & wr_ready;
  assign mem_we      = w_acc;
  assign mem_waddr   = r_wbin[ADDR_WIDTH-1:0];
  assign w_wbin_nxt  = r_wbin + P'(w_acc);
  assign w_wgray_nxt = P'(bin2gray(GW'(w_wbin_nxt)));
  assign w_rbin      = P'(gray2bin(GW'(rptr_gray_sync)));
  assign w_level_nxt = w_wbin_nxt - w_rbin;
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign w_full_nxt  = w_wgray_nxt == {~rptr_gray_sync[P-1:P-2], rptr_gray_sync[P-3:0]};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_nxt;
      r_wgray <= w_wgray_nxt;
      r_level <= w_level_nxt;
      r_full  <= w_full_nxt;
      r_af    <= w_level_nxt >= AF;
      r_err   <= r_err | (w_level_nxt > DEPTH);
    end
  end
  assign wptr_gray   = r_wgray;
  assign full        = r_full;
  assign almost_full = r_af;
  assign wr_level    = r_level;
  assign ptr_err     = r_err;
endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// tb_afifo_wr_ctrl: scoreboard bench for the write-side controller with a bench-driven synced read pointer.
module tb_afifo_wr_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready, mem_we, full, almost_full, ptr_err;
  logic [3:0] mem_waddr;
  logic [4:0] wptr_gray, rptr_gray_sync = '0, wr_level;
  int n_pass = 0, n_tot = 0;
  logic [4:0] m_wbin, m_level;
  logic       m_full, m_af, m_err, m_run;
  int         m_cnt;
  logic [3:0] sb_q[$];
  always #5 clk = ~clk;
  afifo_wr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .AF_LEVEL(12)) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .wptr_gray(wptr_gray),
    .rptr_gray_sync(rptr_gray_sync), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .ptr_err(ptr_err)
  );
  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset();
    m_wbin = '0; m_level = '0; m_full = 0; m_af = 0; m_err = 0; m_run = 0; m_cnt = 0;
  endtask
  // One cycle: drive at negedge, check combinational outputs, advance model, check registers.
  task automatic tick(input logic v, input logic [4:0] rb);
    logic       rdy, acc;
    logic [4:0] wn, ln;
    wr_valid = v;
    rptr_gray_sync = b2g(rb);
    #1;
    rdy = m_run & ~m_full;
    acc = v & rdy;
    chk("wr_ready", wr_ready, rdy);
    chk("mem_we", mem_we, acc);
    if (acc) sb_q.push_back(m_wbin[3:0]);
    if (mem_we) begin
      if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("mem_waddr", mem_waddr, sb_q.pop_front());
    end
    wn = m_wbin + 5'(acc);
    ln = wn - rb;
    @(posedge clk);
    if (!resetn) model_reset();
    else begin
      m_wbin = wn; m_level = ln; m_full = ln == 5'd16; m_af = ln >= 5'd12;
      m_err = m_err | (ln > 5'd16);
      if (!m_run) begin
        if (m_cnt == 2) m_run = 1; else m_cnt++;
      end
    end
    @(negedge clk);
    chk("wptr_gray", wptr_gray, b2g(m_wbin));
    chk("full", full, m_full);
    chk("almost_full", almost_full, m_af);
    chk("wr_level", wr_level, m_level);
    chk("ptr_err", ptr_err, m_err);
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    resetn = 0;
    tick(1, 0);
    tick(1, 0);
    resetn = 1;
    for (int i = 0; i < 3; i++) tick(1, 0);
    chk("init_no_write", m_wbin, 0);
    tick(1, 0);
    chk("first_gray", wptr_gray, 5'h01);
    for (int i = 0; i < 16; i++) tick(1, 0);
    chk("full_at_16", full, 1);
    chk("level_16", wr_level, 16);
    chk("ready_low_full", wr_ready, 0);
    tick(1, 1);
    chk("full_clear", full, 0);
    chk("level_15", wr_level, 15);
    tick(1, 1);
    chk("wrap_addr0", m_wbin, 17);
    for (int i = 0; i < 40; i++) tick(1, m_wbin - 5'd2);
    chk("wrap_no_err", ptr_err, 0);
    tick(0, m_wbin - 5'd17);
    chk("err_set", ptr_err, 1);
    for (int i = 0; i < 4; i++) tick(1, m_wbin);
    chk("err_sticky", ptr_err, 1);
    resetn = 0;
    tick(1, 0);
    chk("err_cleared", ptr_err, 0);
    resetn = 1;
    for (int i = 0; i < 3; i++) tick(1, 0);
    for (int i = 0; i < 7; i++) tick(1, 0);
    chk("wbin7", wptr_gray, b2g(5'd7));
    resetn = 0;
    tick(1, 0);
    chk("mid_reset_gray", wptr_gray, 0);
    chk("mid_reset_level", wr_level, 0);
    resetn = 1;
    for (int i = 0; i < 4; i++) tick(1, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
